// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding, SRAM geometry and byte-merge helper for the ICB SRAM controller
package sram_ctrl_pkg;
  localparam int SRAM_AW = 13;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WR, RSP} state_e;
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] mask);
    for (int i = 0; i < 4; i++) byte_merge[8*i+:8] = mask[i] ? new_w[8*i+:8] : old_w[8*i+:8];
  endfunction
endpackage

// File: rtl/icb_sram_ctrl_8k.sv
// icb_sram_ctrl_8k: ICB slave driving an 8K x 32 SRAM, partial writes done as read-modify-write
module icb_sram_ctrl_8k
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          AW        = SRAM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          icb_cmd_valid,
  output logic          icb_cmd_ready,
  input  logic [31:0]   icb_cmd_addr,
  input  logic          icb_cmd_read,
  input  logic [31:0]   icb_cmd_wdata,
  input  logic [3:0]    icb_cmd_wmask,
  output logic          icb_rsp_valid,
  input  logic          icb_rsp_ready,
  output logic [31:0]   icb_rsp_rdata,
  output logic          icb_rsp_err,
  output logic          sram_csbn,
  output logic          sram_wsbn,
  output logic [AW-1:0] sram_waddr,
  output logic [31:0]   sram_wdata,
  output logic [AW-1:0] sram_raddr,
  input  logic [31:0]   sram_rdata
);
  state_e        state_q, state_d;
  logic [31:0]   rdata_q, rdata_d, wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [AW-1:0] word_q, word_d;
  logic [3:0]    wmask_q, wmask_d;
  logic          accept, hit, unused;
  logic [AW-1:0] word;
  assign hit           = icb_cmd_addr[31:AW+2] == BASE_ADDR[31:AW+2];
  assign word          = icb_cmd_addr[AW+1:2];
  assign unused        = ^icb_cmd_addr[1:0];
  assign icb_cmd_ready = state_q == IDLE;
  assign accept        = icb_cmd_valid && icb_cmd_ready;
  assign icb_rsp_valid = state_q == RSP;
  assign icb_rsp_rdata = rdata_q;
  assign icb_rsp_err   = err_q;
  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    sram_csbn  = 1'b1;
    sram_wsbn  = 1'b1;
    sram_waddr = '0;
    sram_wdata = '0;
    sram_raddr = '0;
    case (state_q)
      IDLE: if (accept) begin
        rdata_d = '0;
        err_d   = !hit;
        state_d = RSP;
        if (hit && icb_cmd_read) begin
          sram_csbn  = 1'b0;
          sram_raddr = word;
          state_d    = RD_WAIT;
        end else if (hit && icb_cmd_wmask == 4'hF) begin
          sram_csbn  = 1'b0;
          sram_wsbn  = 1'b0;
          sram_waddr = word;
          sram_wdata = icb_cmd_wdata;
        end else if (hit && icb_cmd_wmask != 4'h0) begin
          sram_csbn  = 1'b0;
          sram_raddr = word;
          word_d     = word;
          wdata_d    = icb_cmd_wdata;
          wmask_d    = icb_cmd_wmask;
          state_d    = RMW_WR;
        end
      end
      RD_WAIT: begin
        rdata_d = sram_rdata;
        state_d = RSP;
      end
      RMW_WR: begin
        sram_csbn  = 1'b0;
        sram_wsbn  = 1'b0;
        sram_waddr = word_q;
        sram_wdata = byte_merge(sram_rdata, wdata_q, wmask_q);
        state_d    = RSP;
      end
      RSP: state_d = icb_rsp_ready ? IDLE : RSP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end
endmodule

// File: tb/tb_icb_sram_ctrl_8k.sv
// tb_icb_sram_ctrl_8k: scoreboard bench for the ICB SRAM controller with a behavioural 8K x 32 SRAM
module tb_icb_sram_ctrl_8k;
  localparam int AW = 13;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_read = 1'b0;
  logic [31:0]   cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]    cmd_wmask = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          csbn, wsbn;
  logic [AW-1:0] waddr, raddr;
  logic [31:0]   wdata, rdata = '0;
  logic [31:0]   mem [2**AW];
  int            n_chk = 0, n_pass = 0, cyc = 0, wr_cnt = 0, en_cnt = 0;
  logic [AW-1:0] last_waddr = '0;
  logic [32:0]   sb [$];
  int            acc_q [$];

  icb_sram_ctrl_8k dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(cmd_valid), .icb_cmd_ready(cmd_ready), .icb_cmd_addr(cmd_addr),
    .icb_cmd_read(cmd_read), .icb_cmd_wdata(cmd_wdata), .icb_cmd_wmask(cmd_wmask),
    .icb_rsp_valid(rsp_valid), .icb_rsp_ready(rsp_ready), .icb_rsp_rdata(rsp_rdata),
    .icb_rsp_err(rsp_err), .sram_csbn(csbn), .sram_wsbn(wsbn), .sram_waddr(waddr),
    .sram_wdata(wdata), .sram_raddr(raddr), .sram_rdata(rdata)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 2**AW; i++) mem[i] = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!csbn && !wsbn) mem[waddr] <= wdata;
    else if (!csbn) rdata <= mem[raddr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!csbn) en_cnt++;
    if (!csbn && !wsbn) begin
      wr_cnt++;
      last_waddr = waddr;
    end
    if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e[32:1]);
        chk("rsp_err", rsp_err, e[0]);
      end
    end
  end

  task automatic txn(input logic [31:0] a, input logic rd, input logic [31:0] wd, input logic [3:0] m,
                     input logic [31:0] er, input logic ee, input int lat, input int stall);
    int n;
    @(posedge clk); #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_read = rd; cmd_wdata = wd; cmd_wmask = m;
    rsp_ready = (stall == 0);
    sb.push_back({er, ee});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, lat);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdata", rsp_rdata, er);
      chk("stall_ready", cmd_ready, 0);
      chk("stall_csbn", csbn, 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_to_idle", cmd_ready, 1);
  endtask

  initial begin
    int w0, e0, n;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_csbn", csbn, 1);
    chk("rst_wsbn", wsbn, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    txn(32'h8000_0010, 0, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, 0);
    chk("full_waddr", last_waddr, 4);
    txn(32'h8000_0010, 1, 0, 0, 32'hDEAD_BEEF, 0, 2, 0);

    w0 = wr_cnt;
    txn(32'h8000_0010, 0, 32'h1122_3344, 4'b0101, 0, 0, 2, 0);
    chk("rmw_one_write", wr_cnt - w0, 1);
    txn(32'h8000_0010, 1, 0, 0, 32'hDE22_BE44, 0, 2, 0);
    txn(32'h8000_0013, 1, 0, 0, 32'hDE22_BE44, 0, 2, 0);

    e0 = en_cnt;
    txn(32'h8000_8000, 1, 0, 0, 0, 1, 1, 0);
    txn(32'h9000_0000, 1, 0, 0, 0, 1, 1, 0);
    txn(32'h9000_0000, 0, 32'h5555_5555, 4'hF, 0, 1, 1, 0);
    chk("miss_no_enable", en_cnt - e0, 0);

    txn(32'h8000_7FFC, 0, 32'hCAFE_F00D, 4'hF, 0, 0, 1, 0);
    chk("top_waddr", last_waddr, 13'h1FFF);
    txn(32'h8000_7FFC, 1, 0, 0, 32'hCAFE_F00D, 0, 2, 5);

    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = 32'h8000_0010; cmd_read = 1'b0; cmd_wdata = 32'h0; cmd_wmask = 4'b0011;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    w0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_cmd_ready", cmd_ready, 1);
    chk("rstmid_csbn", csbn, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("rstmid_no_write", wr_cnt - w0, 0);
    txn(32'h8000_0010, 1, 0, 0, 32'hDE22_BE44, 0, 2, 0);

    e0 = en_cnt;
    txn(32'h8000_0010, 0, 32'hFFFF_FFFF, 4'h0, 0, 0, 1, 0);
    chk("mask0_no_enable", en_cnt - e0, 0);
    txn(32'h8000_0010, 1, 0, 0, 32'hDE22_BE44, 0, 2, 0);

    acc_q.delete();
    for (int i = 0; i < 3; i++) sb.push_back({32'hDE22_BE44, 1'b0});
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 32'h8000_0010; cmd_read = 1'b1;
    n = 0;
    while (acc_q.size() < 3 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", acc_q.size(), 3);
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_drained", sb.size(), 0);
    if (acc_q.size() >= 3) begin
      chk("b2b_gap1", acc_q[1] - acc_q[0], 3);
      chk("b2b_gap2", acc_q[2] - acc_q[1], 3);
    end
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
